// File: rtl/act_pkg.sv
// Shared types and helpers for the activation pipeline.
// Mode encodings and the zero-lane popcount used by the ACT_STATS_EN counter.
package act_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_RELU   = 2'd1;
    localparam logic [1:0] MODE_LEAKY  = 2'd2;
    localparam logic [1:0] MODE_CLIP   = 2'd3;

    typedef enum logic [1:0] {
        ACT_BYPASS = MODE_BYPASS,
        ACT_RELU   = MODE_RELU,
        ACT_LEAKY  = MODE_LEAKY,
        ACT_CLIP   = MODE_CLIP
    } act_mode_t;

    // Flags are zero-extended per-lane "lane == 0" bits; at most 32 lanes.
    function automatic logic [5:0] popcount_zero(input logic [31:0] zero_flags);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 6'(zero_flags[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/act_lane.sv
// Single-lane combinational activation function.
// Every mode result fits in WDP bits, so no saturation is required.
module act_lane
    import act_pkg::*;
#(
    parameter int unsigned WDP        = 9,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic signed [WDP-1:0] x_i,
    input  act_mode_t             mode_i,
    input  logic signed [WDP-1:0] clip_i,
    output logic signed [WDP-1:0] y_o
);

    logic signed [WDP-1:0] clip_pos;

    always_comb begin
        clip_pos = clip_i[WDP-1] ? '0 : clip_i;
        y_o      = x_i;
        unique case (mode_i)
            ACT_BYPASS: y_o = x_i;
            ACT_RELU:   y_o = x_i[WDP-1] ? '0 : x_i;
            // Arithmetic shift floors toward minus infinity: -1 stays -1.
            ACT_LEAKY:  y_o = x_i[WDP-1] ? (x_i >>> LEAK_SHIFT) : x_i;
            ACT_CLIP: begin
                if (x_i[WDP-1]) begin
                    y_o = '0;
                end else if (x_i > clip_pos) begin
                    y_o = clip_pos;
                end else begin
                    y_o = x_i;
                end
            end
            default:    y_o = x_i;
        endcase
    end

endmodule

// File: rtl/act_pipe.sv
// Two-stage, CH-lane activation pipeline with valid/ready backpressure.
// Define ACT_STATS_EN to add the stat_clr / zero_cnt zero-lane counter.
module act_pipe
    import act_pkg::*;
#(
    parameter int unsigned CH         = 6,
    parameter int unsigned WDP        = 9,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          mode_i,
    input  logic [WDP-1:0]      clip_i,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WDP*CH-1:0]   data_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WDP*CH-1:0]   q
`ifdef ACT_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [31:0]         zero_cnt
`endif
);

    logic              v1_q, v2_q;
    logic [WDP*CH-1:0] d1_q, q2_q;
    act_mode_t         mode1_q;
    logic [WDP-1:0]    clip1_q;
    logic [WDP*CH-1:0] act_y;
    logic              en1, en2;

    always_comb begin
        en2      = !v2_q || out_ready;
        en1      = !v1_q || en2;
        in_ready = en1;
    end

    assign out_valid = v2_q;
    assign q         = q2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q    <= 1'b0;
            d1_q    <= '0;
            mode1_q <= ACT_BYPASS;
            clip1_q <= '0;
        end else if (en1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                d1_q    <= data_i;
                mode1_q <= act_mode_t'(mode_i);
                clip1_q <= clip_i;
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_lane
        act_lane #(
            .WDP        (WDP),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .x_i    (d1_q[WDP*CH-1-i*WDP -: WDP]),
            .mode_i (mode1_q),
            .clip_i (clip1_q),
            .y_o    (act_y[WDP*CH-1-i*WDP -: WDP])
        );
    end

    // S2 only reloads on a real beat so q stays put through bubbles and stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2_q <= 1'b0;
            q2_q <= '0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                q2_q <= act_y;
            end
        end
    end

`ifdef ACT_STATS_EN
    logic [CH-1:0] lane_zero;
    logic [31:0]   zero_flags;
    logic [32:0]   zero_sum;
    logic [31:0]   zero_cnt_d, zero_cnt_q;

    for (genvar i = 0; i < CH; i++) begin : g_zero
        assign lane_zero[i] = (q2_q[WDP*CH-1-i*WDP -: WDP] == '0);
    end

    always_comb begin
        zero_flags = 32'(lane_zero);
        zero_sum   = {1'b0, zero_cnt_q} + {27'd0, popcount_zero(zero_flags)};
        zero_cnt_d = zero_cnt_q;
        if (stat_clr) begin
            zero_cnt_d = '0;
        end else if (v2_q && out_ready) begin
            zero_cnt_d = zero_sum[32] ? '1 : zero_sum[31:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            zero_cnt_q <= '0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign zero_cnt = zero_cnt_q;
`endif

endmodule
